// File: rtl/bbox_scan.sv
// Raster-scans the 1-bit value RAM and reports the dark-pixel bounding box and count.
// Optional feature macro BBOX_MIN_COUNT_EN: found requires at least MIN_DARK dark pixels.
module bbox_scan #(
    parameter int unsigned ADDR_WIDTH_2 = 16,
    parameter int unsigned COORD_W      = 16,
    parameter int unsigned RAM_LATENCY  = 2,
    parameter int unsigned MIN_DARK     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [COORD_W-1:0]      width,
    input  logic [COORD_W-1:0]      height,
    input  logic                    start,
    output logic [ADDR_WIDTH_2-1:0] addra_dmn,
    input  logic                    douta_dmn,
    output logic                    busy,
    output logic                    done,
    output logic                    found,
    output logic [COORD_W-1:0]      x_min,
    output logic [COORD_W-1:0]      x_max,
    output logic [COORD_W-1:0]      y_min,
    output logic [COORD_W-1:0]      y_max,
    output logic [ADDR_WIDTH_2:0]   dark_cnt
);

    localparam int unsigned PW = 2 * COORD_W;
    localparam logic [PW-1:0] MaxAddr = PW'({ADDR_WIDTH_2{1'b1}});

    if (RAM_LATENCY < 1 || RAM_LATENCY > 4 || PW <= ADDR_WIDTH_2 ||
        64'(MIN_DARK) > ((64'd1 << (ADDR_WIDTH_2 + 1)) - 64'd1)) begin : g_param_check
        $error("bbox_scan: illegal parameter combination");
    end

    typedef enum logic [2:0] {StIdle, StIssue, StDrain, StDone, StWaitLow} state_e;

    state_e                  state_q;
    logic [COORD_W-1:0]      width_q;
    logic [ADDR_WIDTH_2-1:0] last_q;
    logic [COORD_W-1:0]      x_q;
    logic [COORD_W-1:0]      y_q;
    logic [2:0]              drain_q;
    logic                    tag_v [RAM_LATENCY];
    logic [COORD_W-1:0]      tag_x [RAM_LATENCY];
    logic [COORD_W-1:0]      tag_y [RAM_LATENCY];

    logic [PW-1:0]           prod;
    logic [PW-1:0]           prod_m1;
    logic [ADDR_WIDTH_2-1:0] last_addr;

    // Last address to issue, clamped to the top of the RAM when the image is too large.
    always_comb begin
        prod      = {{COORD_W{1'b0}}, width} * {{COORD_W{1'b0}}, height};
        prod_m1   = prod - PW'(1);
        last_addr = (prod_m1 > MaxAddr) ? {ADDR_WIDTH_2{1'b1}} : prod_m1[ADDR_WIDTH_2-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            addra_dmn <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            found     <= 1'b0;
            x_min     <= '1;
            y_min     <= '1;
            x_max     <= '0;
            y_max     <= '0;
            dark_cnt  <= '0;
            width_q   <= '0;
            last_q    <= '0;
            x_q       <= '0;
            y_q       <= '0;
            drain_q   <= '0;
            for (int i = 0; i < RAM_LATENCY; i++) begin
                tag_v[i] <= 1'b0;
                tag_x[i] <= '0;
                tag_y[i] <= '0;
            end
        end else begin
            // Tag of the address currently on addra_dmn; emerges alongside its read data.
            tag_v[0] <= (state_q == StIssue);
            tag_x[0] <= x_q;
            tag_y[0] <= y_q;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_x[i] <= tag_x[i-1];
                tag_y[i] <= tag_y[i-1];
            end

            if (tag_v[RAM_LATENCY-1] && douta_dmn) begin
                if (tag_x[RAM_LATENCY-1] < x_min) x_min <= tag_x[RAM_LATENCY-1];
                if (tag_x[RAM_LATENCY-1] > x_max) x_max <= tag_x[RAM_LATENCY-1];
                if (tag_y[RAM_LATENCY-1] < y_min) y_min <= tag_y[RAM_LATENCY-1];
                if (tag_y[RAM_LATENCY-1] > y_max) y_max <= tag_y[RAM_LATENCY-1];
                if (dark_cnt != '1) dark_cnt <= dark_cnt + (ADDR_WIDTH_2 + 1)'(1);
            end

            unique case (state_q)
                StIdle: begin
                    addra_dmn <= '0;
                    if (start) begin
                        width_q  <= width;
                        last_q   <= last_addr;
                        x_q      <= '0;
                        y_q      <= '0;
                        x_min    <= '1;
                        y_min    <= '1;
                        x_max    <= '0;
                        y_max    <= '0;
                        dark_cnt <= '0;
                        found    <= 1'b0;
                        if (prod == '0) begin
                            state_q <= StDone;
                        end else begin
                            busy    <= 1'b1;
                            state_q <= StIssue;
                        end
                    end
                end
                StIssue: begin
                    if (addra_dmn == last_q) begin
                        drain_q <= '0;
                        state_q <= StDrain;
                    end else begin
                        addra_dmn <= addra_dmn + ADDR_WIDTH_2'(1);
                        if (x_q == width_q - COORD_W'(1)) begin
                            x_q <= '0;
                            y_q <= y_q + COORD_W'(1);
                        end else begin
                            x_q <= x_q + COORD_W'(1);
                        end
                    end
                end
                StDrain: begin
                    if (drain_q == 3'(RAM_LATENCY - 1)) state_q <= StDone;
                    else drain_q <= drain_q + 3'd1;
                end
                StDone: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
`ifdef BBOX_MIN_COUNT_EN
                    found <= (dark_cnt >= (ADDR_WIDTH_2 + 1)'(MIN_DARK));
`else
                    found <= (dark_cnt != '0);
`endif
                    state_q <= StWaitLow;
                end
                StWaitLow: begin
                    if (!start) begin
                        done    <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_bbox_scan.sv
// Directed bench for bbox_scan: behavioural value RAM, expected results queued per scan.
module tb_bbox_scan;

    localparam int unsigned AW  = 8;
    localparam int unsigned CW  = 16;
    localparam int unsigned LAT = 2;
    localparam int unsigned MIN = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] width, height;
    logic          start;
    logic [AW-1:0] addra_dmn;
    logic          douta_dmn;
    logic          busy, done, found;
    logic [CW-1:0] x_min, x_max, y_min, y_max;
    logic [AW:0]   dark_cnt;

    bbox_scan #(
        .ADDR_WIDTH_2(AW),
        .COORD_W     (CW),
        .RAM_LATENCY (LAT),
        .MIN_DARK    (MIN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .width    (width),
        .height   (height),
        .start    (start),
        .addra_dmn(addra_dmn),
        .douta_dmn(douta_dmn),
        .busy     (busy),
        .done     (done),
        .found    (found),
        .x_min    (x_min),
        .x_max    (x_max),
        .y_min    (y_min),
        .y_max    (y_max),
        .dark_cnt (dark_cnt)
    );

    always #5 clk = ~clk;

    // Value RAM with LAT cycles of read latency.
    logic mem  [256];
    logic pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= mem[addra_dmn];
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign douta_dmn = pipe[LAT-1];

    typedef struct {
        logic          found;
        logic [CW-1:0] x_min, x_max, y_min, y_max;
        int            cnt;
        int            lat;
        int            last;
        logic          busy1;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int w, input int h);
        exp_t e;
        int   n;
        e.x_min = '1;
        e.x_max = '0;
        e.y_min = '1;
        e.y_max = '0;
        e.cnt   = 0;
        n = w * h;
        if (n > 256) n = 256;
        for (int a = 0; a < n; a++) begin
            if (mem[a]) begin
                if (CW'(a % w) < e.x_min) e.x_min = CW'(a % w);
                if (CW'(a % w) > e.x_max) e.x_max = CW'(a % w);
                if (CW'(a / w) < e.y_min) e.y_min = CW'(a / w);
                if (CW'(a / w) > e.y_max) e.y_max = CW'(a / w);
                e.cnt++;
            end
        end
`ifdef BBOX_MIN_COUNT_EN
        e.found = (e.cnt >= MIN);
`else
        e.found = (e.cnt != 0);
`endif
        e.lat   = (n == 0) ? 2 : n + LAT + 2;
        e.last  = (n == 0) ? 0 : n - 1;
        e.busy1 = (n != 0);
        return e;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 1'b0;
    endtask

    task automatic begin_scan(input int w, input int h);
        width  = CW'(w);
        height = CW'(h);
        sb.push_back(model(w, h));
        start  = 1'b1;
    endtask

    // Called right after start (or reset release with start high) at a negedge.
    task automatic wait_and_check(input string name);
        exp_t e;
        int   cyc;
        int   max_addr;
        logic busy1;
        cyc      = 0;
        max_addr = 0;
        busy1    = 1'b0;
        while (done !== 1'b1 && cyc < 2000) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (int'(addra_dmn) > max_addr) max_addr = int'(addra_dmn);
            if (cyc == 1) busy1 = busy;
        end
        check({name, ".queue"}, 32'(sb.size()), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check({name, ".lat"}, 32'(cyc), 32'(e.lat));
        check({name, ".busy1"}, 32'(busy1), 32'(e.busy1));
        check({name, ".found"}, 32'(found), 32'(e.found));
        check({name, ".x_min"}, 32'(x_min), 32'(e.x_min));
        check({name, ".x_max"}, 32'(x_max), 32'(e.x_max));
        check({name, ".y_min"}, 32'(y_min), 32'(e.y_min));
        check({name, ".y_max"}, 32'(y_max), 32'(e.y_max));
        check({name, ".cnt"}, 32'(dark_cnt), 32'(e.cnt));
        check({name, ".busy_done"}, 32'(busy), 32'd0);
        check({name, ".addr_hold"}, 32'(addra_dmn), 32'(e.last));
        check({name, ".addr_max"}, 32'(max_addr), 32'(e.last));
        @(posedge clk);
        @(negedge clk);
        check({name, ".done_held"}, 32'(done), 32'd1);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({name, ".done_fall"}, 32'(done), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check({name, ".addr_idle"}, 32'(addra_dmn), 32'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, ".addr"}, 32'(addra_dmn), 32'd0);
        check({name, ".busy"}, 32'(busy), 32'd0);
        check({name, ".done"}, 32'(done), 32'd0);
        check({name, ".found"}, 32'(found), 32'd0);
        check({name, ".x_min"}, 32'(x_min), 32'hFFFF);
        check({name, ".y_min"}, 32'(y_min), 32'hFFFF);
        check({name, ".x_max"}, 32'(x_max), 32'd0);
        check({name, ".y_max"}, 32'(y_max), 32'd0);
        check({name, ".cnt"}, 32'(dark_cnt), 32'd0);
    endtask

    initial begin
        int guard;
        rst    = 1'b1;
        start  = 1'b0;
        width  = '0;
        height = '0;
        clear_mem();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single dark pixel in a 4x3 map.
        mem[5] = 1'b1;
        begin_scan(4, 3);
        wait_and_check("single");

        // Three scattered dark pixels in an 8x8 map.
        clear_mem();
        mem[9] = 1'b1; mem[22] = 1'b1; mem[50] = 1'b1;
        begin_scan(8, 8);
        wait_and_check("scatter");

        // Nothing dark.
        clear_mem();
        begin_scan(5, 5);
        wait_and_check("empty");

        // Zero width skips straight to the result.
        mem[0] = 1'b1;
        begin_scan(0, 7);
        wait_and_check("zero_w");

        // Reset mid-scan with start held high, then a clean rescan.
        clear_mem();
        mem[3] = 1'b1; mem[20] = 1'b1; mem[35] = 1'b1;
        width  = 16'd6;
        height = 16'd6;
        start  = 1'b1;
        guard  = 0;
        while (addra_dmn !== 8'd10 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("midscan.reach10", 32'(addra_dmn), 32'd10);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midscan_rst");
        rst = 1'b0;
        sb.push_back(model(6, 6));
        wait_and_check("rescan");

        // Three then four dark pixels around the MIN_DARK threshold.
        clear_mem();
        mem[0] = 1'b1; mem[5] = 1'b1; mem[10] = 1'b1;
        begin_scan(4, 4);
        wait_and_check("min3");
        mem[15] = 1'b1;
        begin_scan(4, 4);
        wait_and_check("min4");

        // Image larger than the RAM: only the first 256 addresses are scanned.
        for (int i = 0; i < 256; i++) mem[i] = 1'b1;
        begin_scan(20, 20);
        wait_and_check("trunc");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bbox_scan.md
Name: bbox_scan

Overview:
- Downstream consumer of the binarised value RAM produced by the colour-threshold stage.
- After threshold completion, raster-scans the 1-bit map (address = y*width + x) through that stage's read port (addra_dmn/douta_dmn).
- Reports the bounding box and count of dark pixels (bit = 1) to the QR locate/crop logic.

Parameters:
- ADDR_WIDTH_2, 16, value-RAM address width; matches the threshold stage.
- COORD_W, 16, width of the coordinate and dimension fields.
- RAM_LATENCY, 2, cycles from addra_dmn change to valid douta_dmn; legal range 1..4.
- MIN_DARK, 16, minimum dark-pixel count for found=1; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- width  in  COORD_W  image width in pixels; sampled on start
- height  in  COORD_W  image height in pixels; sampled on start
- start  in  1  level; connect to the upstream completion flag
- addra_dmn  out  ADDR_WIDTH_2  value-RAM read address
- douta_dmn  in  1  value-RAM read data (1 = dark)
- busy  out  1  scan in progress
- done  out  1  result valid; held until start falls
- found  out  1  at least one qualifying dark pixel
- x_min, x_max, y_min, y_max  out  COORD_W each  bounding box, inclusive
- dark_cnt  out  ADDR_WIDTH_2+1  number of dark pixels

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst=1 at a posedge), effective next cycle from any state, including mid-scan:
  - Outputs: addra_dmn=0, busy=0, done=0, found=0, x_min=y_min=all-ones, x_max=y_max=0, dark_cnt=0.
  - State returns to IDLE; pending pipeline entries are discarded.
- FSM states: IDLE, ISSUE, DRAIN, DONE, WAIT_LOW.
  - IDLE:
    - On start=1: latch width and height; clear the accumulators and set mins to all-ones.
    - If width=0 or height=0: go directly to DONE with found=0.
    - Otherwise go to ISSUE; busy=1 from the next cycle.
  - ISSUE:
    - Present one address per cycle, 0 .. N-1, where N = width*height computed at full 2*COORD_W width.
    - Issue counters x and y: x increments; when x=width-1 it wraps to 0 and y increments.
    - Each issued address pushes (x, y, valid=1) into a RAM_LATENCY-deep tag shift register, so the tag arrives aligned with its douta_dmn.
    - After address N-1 is issued, go to DRAIN.
    - If N > 2^ADDR_WIDTH_2, issuing stops after address 2^ADDR_WIDTH_2-1 and the FSM goes to DRAIN; the result covers only the truncated region.
  - DRAIN: wait RAM_LATENCY cycles for the tag pipeline to empty, then go to DONE.
  - DONE:
    - done=1, busy=0; final results are stable.
    - Go to WAIT_LOW.
  - WAIT_LOW:
    - Hold done=1.
    - When start=0: done falls the next cycle; go to IDLE.
    - A new scan requires start to fall, then rise again.
- Accumulation, for each aligned tag with valid=1 and douta_dmn=1:
  - Update x_min/x_max and y_min/y_max with unsigned compares.
  - dark_cnt saturates at its all-ones value.
- Result registers:
  - Update live during the scan; consumers read them only while done=1.
  - found = (dark_cnt != 0), registered on entry to DONE.
  - found=0 leaves the bounding-box outputs at their cleared values.
- addra_dmn holds its last value in DRAIN, DONE and WAIT_LOW; returns to 0 in IDLE.
- Throughput: one pixel per clock. Total latency from start rise to done = 1 + N + RAM_LATENCY + 1 cycles.
- A start=0 during ISSUE or DRAIN is ignored; the scan runs to completion.

Optional Feature:
- Macro: BBOX_MIN_COUNT_EN.
- Defined: found = (dark_cnt >= MIN_DARK). This suppresses noise specks; the bounding-box registers still report the accumulated values.
- Undefined: found = (dark_cnt != 0); MIN_DARK is unused.

Test Plan:
- 4x3 map, only address 5 (x=1, y=1) dark, RAM_LATENCY=2 -> found=1, box (1,1)-(1,1), dark_cnt=1, done 16 cycles after start.
- 8x8 map, dark at addresses 9, 22, 50 -> x_min=1, x_max=6, y_min=1, y_max=6, dark_cnt=3.
- All-zero 5x5 map -> found=0, x_min=y_min=16'hFFFF, x_max=y_max=0, dark_cnt=0.
- width=0, height=7 -> done=1 two cycles after start; addra_dmn never leaves 0; found=0.
- rst asserted mid-scan at address 10 of a 6x6 map, then start held high -> next cycle all outputs at reset values; the rescan result matches a clean run.
- BBOX_MIN_COUNT_EN defined, MIN_DARK=4, 3 dark pixels -> found=0, dark_cnt=3; with 4 dark pixels -> found=1.
